monitor_de_vigilancia: RTL
==========================

Name: monitor_de_vigilancia

Overview:
- Receiving end of the camera-rotation interface: samples the nine camera-enable lines S0..S8 driven by the surveillance sequencer and decodes which camera group is active.
- Checks that the rotation protocol is respected and flags protocol faults.
- Keeps per-group visit counters that a supervisor can read.
- Sits between the sequencer and the recording/supervision logic.

Parameters:
- MAX_DWELL, 2, max consecutive cycles one group may stay active before a timeout (the sequencer holds group 2 for 2 cycles).
- COUNT_W, 8, width of each per-group visit counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; initialises all state and counters.
- cam_en  input  9  camera-enable lines, bit i = Si.
- limpar  input  1  clear-fault pulse; leaves FAULT and clears the error flags.
- sel_grupo  input  2  selects which visit counter appears on visitas.
- grupo_ativo  output  2  decoded active group (0..2), registered.
- grupo_valido  output  1  high when grupo_ativo holds a legitimately tracked group.
- erro_padrao  output  1  sticky: an illegal enable pattern was seen.
- erro_sequencia  output  1  sticky: a group arrived out of order.
- erro_timeout  output  1  sticky: a group exceeded MAX_DWELL.
- em_falha  output  1  high while the FSM is in FAULT.
- visitas  output  COUNT_W  combinational mux of visit counter[sel_grupo]; sel_grupo=3 gives 0.

Behaviour:
- Interface: already decided, one clock domain `clk`; `reset` is synchronous and active-high.
- Reset values: grupo_ativo=0, grupo_valido=0, all erro_* flags=0, em_falha=0, all counters=0, dwell=0, FSM=WAIT_SYNC.
- Pattern decode (combinational on cam_en):
  - 9'h007 is G0; 9'h038 is G1; 9'h1C0 is G2.
  - 9'h000 is APAGADO.
  - Anything else is ILEGAL.
- Latency: every output except visitas updates on the clock edge after the cam_en sample (1 cycle).
- WAIT_SYNC:
  - APAGADO, G1 or G2: ignored, stay in WAIT_SYNC.
  - G0: go to TRACK with cur=0, dwell=1, visits[0]++, grupo_valido=1.
  - ILEGAL: set erro_padrao and go to FAULT.
- TRACK (next(g) = (g+1) mod 3):
  - Same group as cur and dwell<MAX_DWELL: dwell++.
  - Same group as cur and dwell==MAX_DWELL: set erro_timeout, go to FAULT.
  - Group next(cur): cur=next, dwell=1, visits[next]++.
  - Any other group: set erro_sequencia, go to FAULT.
  - APAGADO or ILEGAL: set erro_padrao, go to FAULT.
- FAULT:
  - grupo_valido=0 and em_falha=1; grupo_ativo holds its last value; further cam_en is ignored and flags do not accumulate.
  - limpar: clear all erro_* flags, go to WAIT_SYNC, em_falha=0.
- limpar outside FAULT: clears the flags, no state change.
- Simultaneous reset and limpar: reset wins.
- Visit counters:
  - COUNT_W bits, saturate at all-ones with no wrap.
  - Cleared only by reset; preserved across faults and limpar.
- dwell counter width is $clog2(MAX_DWELL+1); it never exceeds MAX_DWELL.
- Reset asserted mid-rotation: next edge returns to WAIT_SYNC, and the next G0 is required to resync.

Decomposition:
- Package vigilancia_pkg holds:
  - typedef enum grupo_t {G0, G1, G2, APAGADO, ILEGAL};
  - typedef enum estado_t {WAIT_SYNC, TRACK, FAULT};
  - localparams PAD_G0=9'h007, PAD_G1=9'h038, PAD_G2=9'h1C0;
  - function next_grupo().
- One natural sub-module: decodificador_grupo (pure combinational, cam_en to grupo_t), reusable by other consumers of the bus.
- FSM, dwell counter and visit counters stay in the top.

Test Plan:
- Normal rotation: reset, then drive the sequencer pattern 007,038,1C0,1C0 repeated 3 times -> grupo_ativo 0,1,2,2,... one cycle late; grupo_valido=1; no error flags; visitas for groups 0/1/2 = 3/3/3.
- Sync: drive 000,038,1C0 then 007 -> grupo_valido stays 0 until the cycle after 007; visits[1]=visits[2]=0, visits[0]=1.
- Timeout: after sync hold 1C0 for 3 cycles with MAX_DWELL=2 -> erro_timeout=1 and em_falha=1 on the edge after the third sample; grupo_ativo stays 2.
- Sequence and pattern errors: 007 then 1C0 -> erro_sequencia=1. After limpar and resync, 007 then 9'h00F -> erro_padrao=1. After limpar and resync, 007 then 000 -> erro_padrao=1.
- Clear and persistence: in FAULT pulse limpar together with reset=0 -> flags cleared and state WAIT_SYNC, visit counts preserved. Then assert reset and limpar together -> all counts 0.
- Saturation: COUNT_W=2, run 5 full rotations -> visitas for each group reads 3, no wrap.

Source files
------------

// File: rtl/vigilancia_pkg.sv
// Shared types and constants for the camera-rotation monitor.
// Pattern codes, group/state enums and the rotation order helper.
package vigilancia_pkg;

  typedef enum logic [2:0] {
    G0,
    G1,
    G2,
    APAGADO,
    ILEGAL
  } grupo_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    TRACK,
    FAULT
  } estado_t;

  localparam logic [8:0] PAD_G0 = 9'h007;
  localparam logic [8:0] PAD_G1 = 9'h038;
  localparam logic [8:0] PAD_G2 = 9'h1C0;

  function automatic logic [1:0] next_grupo(input logic [1:0] g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

endpackage

// File: rtl/monitor_de_vigilancia_if.sv
// Bus between the sequencer side and the rotation monitor.
// master drives the camera lines and supervisor controls.
interface monitor_de_vigilancia_if #(
  parameter int COUNT_W = 8
);
  logic [8:0]         cam_en;
  logic               limpar;
  logic [1:0]         sel_grupo;
  logic [1:0]         grupo_ativo;
  logic               grupo_valido;
  logic               erro_padrao;
  logic               erro_sequencia;
  logic               erro_timeout;
  logic               em_falha;
  logic [COUNT_W-1:0] visitas;

  modport master (
    output cam_en,
    output limpar,
    output sel_grupo,
    input  grupo_ativo,
    input  grupo_valido,
    input  erro_padrao,
    input  erro_sequencia,
    input  erro_timeout,
    input  em_falha,
    input  visitas
  );

  modport slave (
    input  cam_en,
    input  limpar,
    input  sel_grupo,
    output grupo_ativo,
    output grupo_valido,
    output erro_padrao,
    output erro_sequencia,
    output erro_timeout,
    output em_falha,
    output visitas
  );
endinterface

// File: rtl/monitor_de_vigilancia_decod.sv
// Combinational decode of the nine camera-enable lines.
// Any pattern other than a full group or all-off is illegal.
module decodificador_grupo
  import vigilancia_pkg::*;
(
  input  logic [8:0] i_cam_en,
  output grupo_t     o_grupo
);

  always_comb begin
    o_grupo = ILEGAL;
    unique case (1'b1)
      (i_cam_en == PAD_G0): o_grupo = G0;
      (i_cam_en == PAD_G1): o_grupo = G1;
      (i_cam_en == PAD_G2): o_grupo = G2;
      (i_cam_en == 9'h000): o_grupo = APAGADO;
      default:              o_grupo = ILEGAL;
    endcase
  end

endmodule

// File: rtl/monitor_de_vigilancia.sv
// Rotation protocol monitor: sync on G0, track order and dwell,
// latch sticky faults and count visits per camera group.
module monitor_de_vigilancia
  import vigilancia_pkg::*;
#(
  parameter int MAX_DWELL = 2,
  parameter int COUNT_W   = 8
) (
  input logic                     clk,
  input logic                     reset,
  monitor_de_vigilancia_if.slave  bus
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);
  localparam logic [DW-1:0] UM    = DW'(1);

  estado_t            r_estado;
  estado_t            w_estado_nxt;
  grupo_t             w_grupo;
  logic [1:0]         w_gidx;
  logic               w_eh_grupo;
  logic [1:0]         r_cur;
  logic [1:0]         w_cur_nxt;
  logic [DW-1:0]      r_dwell;
  logic [DW-1:0]      w_dwell_nxt;
  logic [COUNT_W-1:0] r_vis [3];
  logic [2:0]         w_inc;
  logic               w_set_pad;
  logic               w_set_seq;
  logic               w_set_tmo;
  logic               w_falha;
  logic               r_erro_pad;
  logic               r_erro_seq;
  logic               r_erro_tmo;
  logic [COUNT_W-1:0] w_visitas;

  decodificador_grupo u_dec (
    .i_cam_en (bus.cam_en),
    .o_grupo  (w_grupo)
  );

  assign w_gidx     = w_grupo[1:0];
  assign w_eh_grupo = (w_grupo == G0) || (w_grupo == G1) || (w_grupo == G2);
  assign w_falha    = w_set_pad | w_set_seq | w_set_tmo;

  always_ff @(posedge clk) begin
    if (reset) r_estado <= WAIT_SYNC;
    else       r_estado <= w_estado_nxt;
  end

  always_comb begin
    w_estado_nxt = r_estado;
    unique case (r_estado)
      WAIT_SYNC: begin
        if (w_grupo == G0) w_estado_nxt = TRACK;
        else if (w_falha)  w_estado_nxt = FAULT;
      end
      TRACK: begin
        if (w_falha) w_estado_nxt = FAULT;
      end
      FAULT: begin
        if (bus.limpar) w_estado_nxt = WAIT_SYNC;
      end
      default: w_estado_nxt = WAIT_SYNC;
    endcase
  end

  always_comb begin
    w_set_pad   = 1'b0;
    w_set_seq   = 1'b0;
    w_set_tmo   = 1'b0;
    w_inc       = 3'b000;
    w_cur_nxt   = r_cur;
    w_dwell_nxt = r_dwell;
    unique case (r_estado)
      WAIT_SYNC: begin
        if (w_grupo == G0) begin
          w_cur_nxt   = 2'd0;
          w_dwell_nxt = UM;
          w_inc       = 3'b001;
        end else if (w_grupo == ILEGAL) begin
          w_set_pad = 1'b1;
        end
      end
      TRACK: begin
        if (!w_eh_grupo) begin
          w_set_pad = 1'b1;
        end else if (w_gidx == r_cur) begin
          if (r_dwell < MAX_D) w_dwell_nxt = r_dwell + UM;
          else                 w_set_tmo   = 1'b1;
        end else if (w_gidx == next_grupo(r_cur)) begin
          w_cur_nxt   = w_gidx;
          w_dwell_nxt = UM;
          w_inc       = 3'b001 << w_gidx;
        end else begin
          w_set_seq = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A fault detected in the same cycle as limpar still latches its flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur      <= 2'd0;
      r_dwell    <= '0;
      r_erro_pad <= 1'b0;
      r_erro_seq <= 1'b0;
      r_erro_tmo <= 1'b0;
      for (int i = 0; i < 3; i++) r_vis[i] <= '0;
    end else begin
      r_cur      <= w_cur_nxt;
      r_dwell    <= w_dwell_nxt;
      r_erro_pad <= w_set_pad | (r_erro_pad & ~bus.limpar);
      r_erro_seq <= w_set_seq | (r_erro_seq & ~bus.limpar);
      r_erro_tmo <= w_set_tmo | (r_erro_tmo & ~bus.limpar);
      for (int i = 0; i < 3; i++) begin
        if (w_inc[i] && (r_vis[i] != '1))
          r_vis[i] <= r_vis[i] + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_visitas = '0;
    case (bus.sel_grupo)
      2'd0:    w_visitas = r_vis[0];
      2'd1:    w_visitas = r_vis[1];
      2'd2:    w_visitas = r_vis[2];
      default: w_visitas = '0;
    endcase
  end

  assign bus.grupo_ativo    = r_cur;
  assign bus.grupo_valido   = (r_estado == TRACK);
  assign bus.em_falha       = (r_estado == FAULT);
  assign bus.erro_padrao    = r_erro_pad;
  assign bus.erro_sequencia = r_erro_seq;
  assign bus.erro_timeout   = r_erro_tmo;
  assign bus.visitas        = w_visitas;

endmodule
